// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared tick-counter helpers and encodings for the PWM capture block
package pwm_capture_pkg;

    localparam int unsigned STATIC_PERIOD = 0;

    typedef enum logic [1:0] {
        EV_IDLE,
        EV_TICK,
        EV_RISE,
        EV_TIMEOUT
    } ev_e;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

endpackage

// File: rtl/pwm_capture_channel.sv
// pwm_capture_channel: synchronizes one PWM input and measures its high time and period
module pwm_capture_channel
    import pwm_capture_pkg::*;
#(
    parameter int Resolution = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  in,
    output logic [Resolution-1:0] H,
    output logic [Resolution-1:0] P,
    output logic                  valid
);

    localparam logic [Resolution-1:0] MAX = '1;

    logic                  s1, s2, cur, armed;
    logic [Resolution-1:0] pc, hc;
    ev_e                   ev;

    // s2 is the fresh sample; cur still holds the previous one, so rise is s2 & ~cur
    always_comb begin
        ev = !ce ? EV_IDLE : (s2 & ~cur) ? EV_RISE : (pc == MAX) ? EV_TIMEOUT : EV_TICK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cur   <= 1'b0;
            armed <= 1'b0;
            pc    <= '0;
            hc    <= '0;
            H     <= '0;
            P     <= '0;
            valid <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
            if (ev != EV_IDLE) cur <= s2;
            if (ev == EV_RISE) begin
                if (armed) begin
                    P     <= pc;
                    H     <= hc;
                    valid <= 1'b1;
                end
                armed <= 1'b1;
                pc    <= Resolution'(1);
                hc    <= Resolution'(1);
            end else if (ev == EV_TICK) begin
                pc <= Resolution'(sat_add(32'(pc), 32'd1, 32'(MAX)));
                hc <= Resolution'(sat_add(32'(hc), 32'(s2), 32'(MAX)));
            end else if (ev == EV_TIMEOUT) begin
                P     <= Resolution'(STATIC_PERIOD);
                H     <= s2 ? MAX : '0;
                valid <= 1'b1;
                armed <= 1'b0;
                pc    <= Resolution'(1);
                hc    <= Resolution'(s2);
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: multi-channel PWM high-time/period capture with a registered read port
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int Resolution   = 8,
    parameter int AddressWidth = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic [2**AddressWidth-1:0]   I,
    input  logic [AddressWidth-1:0]      addr,
    output logic [Resolution-1:0]        H,
    output logic [Resolution-1:0]        P,
    output logic                         V,
    output logic [2**AddressWidth-1:0]   Valid
);

    localparam int N = 2**AddressWidth;

    logic [Resolution-1:0] ch_h [N];
    logic [Resolution-1:0] ch_p [N];
    logic [N-1:0]          ch_v;

    for (genvar i = 0; i < N; i++) begin : g_ch
        pwm_capture_channel #(.Resolution(Resolution)) u_ch (
            .clk  (clk),
            .rst  (rst),
            .ce   (ce),
            .in   (I[i]),
            .H    (ch_h[i]),
            .P    (ch_p[i]),
            .valid(ch_v[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            H     <= '0;
            P     <= '0;
            V     <= 1'b0;
            Valid <= '0;
        end else begin
            H     <= ch_h[addr];
            P     <= ch_p[addr];
            V     <= ch_v[addr];
            Valid <= ch_v;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench against a queue-based model of the capture rules
module tb_pwm_capture;

    localparam int R = 8, AW = 2, N = 4, MAX = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic [N-1:0]  I = '0;
    logic [AW-1:0] addr = '0;
    logic [R-1:0]  H, P;
    logic          V;
    logic [N-1:0]  Valid;

    always #5 clk = ~clk;

    pwm_capture #(.Resolution(R), .AddressWidth(AW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .I(I), .addr(addr),
        .H(H), .P(P), .V(V), .Valid(Valid)
    );

    typedef struct {
        logic [R-1:0] h;
        logic [R-1:0] p;
        logic         v;
        logic [N-1:0] vm;
    } exp_t;

    exp_t sbq[$];
    int   total = 0, bad = 0;

    // model: each channel keeps the samples since its last reference point; its length is the period
    bit d1[N], d2[N], last[N], armed[N], mv[N];
    bit smp[N][$];
    int mh[N], mp[N];

    initial begin
        forever begin
            exp_t e;
            bit   x;
            int   s;
            @(posedge clk);
            e.h = R'(mh[addr]);
            e.p = R'(mp[addr]);
            e.v = mv[addr];
            for (int c = 0; c < N; c++) e.vm[c] = mv[c];
            if (rst) begin
                e.h = '0; e.p = '0; e.v = 1'b0; e.vm = '0;
            end
            sbq.push_back(e);
            for (int c = 0; c < N; c++) begin
                if (rst) begin
                    d1[c] = 0; d2[c] = 0; last[c] = 0; armed[c] = 0; mv[c] = 0;
                    mh[c] = 0; mp[c] = 0; smp[c].delete();
                end else begin
                    x = d2[c];
                    d2[c] = d1[c];
                    d1[c] = I[c];
                    if (ce) begin
                        if (x && !last[c]) begin
                            if (armed[c]) begin
                                s = 0;
                                foreach (smp[c][k]) s += int'(smp[c][k]);
                                mp[c] = smp[c].size();
                                mh[c] = s;
                                mv[c] = 1;
                            end
                            armed[c] = 1;
                            smp[c].delete();
                            smp[c].push_back(x);
                        end else if (smp[c].size() == MAX) begin
                            mp[c] = 0;
                            mh[c] = x ? MAX : 0;
                            mv[c] = 1;
                            armed[c] = 0;
                            smp[c].delete();
                            smp[c].push_back(x);
                        end else begin
                            smp[c].push_back(x);
                        end
                        last[c] = x;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                total++;
                if ({H, P, V, Valid} !== {e.h, e.p, e.v, e.vm}) begin
                    bad++;
                    $display("FAIL rd t=%0t addr=%0d got H=%0d P=%0d V=%0d Valid=%b exp H=%0d P=%0d V=%0d Valid=%b",
                             $time, addr, H, P, V, Valid, e.h, e.p, e.v, e.vm);
                end
            end
        end
    end

    int per[N], hi[N], ph[N];
    int tk = 0, div = 1, dcnt = 0;

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            ce = (div != 0) && (dcnt == 0);
            if (div != 0) dcnt = (dcnt + 1) % div;
            for (int c = 0; c < N; c++) I[c] = ((tk + ph[c]) % per[c]) < hi[c];
            if (ce) tk++;
        end
    endtask

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", n, a, e);
        end
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            per[c] = 1; hi[c] = 0; ph[c] = 0;
        end
        per[0] = 4; hi[0] = 1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(20);
        chk("t1_h", int'(H), 1);
        chk("t1_p", int'(P), 4);
        chk("t1_v", int'(V), 1);
        chk("t1_valid_others", int'(Valid[3:1]), 0);

        div = 3; dcnt = 0;
        per[2] = 8; hi[2] = 5;
        addr = 2;
        cyc(96);
        chk("t2_h", int'(H), 5);
        chk("t2_p", int'(P), 8);
        addr = 1;
        cyc(1);
        chk("t2_addr1_v", int'(V), 0);
        chk("t2_valid2", int'(Valid[2]), 1);

        div = 1; dcnt = 0;
        per[1] = 1; hi[1] = 1;
        cyc(300);
        chk("t3_timeout_p", int'(P), 0);
        chk("t3_timeout_h", int'(H), 255);
        chk("t3_timeout_v", int'(V), 1);
        per[1] = 10; hi[1] = 3;
        cyc(40);
        chk("t3_rearm_p", int'(P), 10);
        chk("t3_rearm_h", int'(H), 3);

        per[3] = 200; hi[3] = 199;
        addr = 3;
        cyc(700);
        chk("t4_p200", int'(P), 200);
        chk("t4_h199", int'(H), 199);
        per[3] = 255; hi[3] = 100;
        cyc(1000);
        chk("t4_p255", int'(P), 255);
        chk("t4_h100", int'(H), 100);

        addr = 0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t5_rst_h", int'(H), 0);
        chk("t5_rst_p", int'(P), 0);
        chk("t5_rst_v", int'(V), 0);
        chk("t5_rst_valid", int'(Valid), 0);
        cyc(20);
        chk("t5_resume_p", int'(P), 4);
        chk("t5_resume_h", int'(H), 1);

        div = 0;
        for (int c = 0; c < N; c++) begin
            per[c] = 2 + c; hi[c] = 1;
        end
        repeat (50) begin
            tk++;
            cyc(1);
        end
        chk("t6_hold_p", int'(P), 4);
        chk("t6_hold_h", int'(H), 1);

        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < N; c++) begin
                per[c] = $urandom_range(1, 300);
                hi[c]  = $urandom_range(0, per[c]);
                ph[c]  = $urandom_range(0, 299);
            end
            div = $urandom_range(1, 3);
            dcnt = 0;
            repeat (120) begin
                addr = AW'($urandom_range(0, N - 1));
                rst = ($urandom_range(0, 599) == 0);
                cyc(1);
            end
        end
        rst = 1'b0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
